// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: parametrised N-digit BCD up/down counter.
// Parameters:
//   DIGITS  number of BCD digits (1..8), range 0 .. 10^DIGITS-1
//   WRAP    0 = hold at max/min, 1 = roll over max->0 and 0->max
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   inc/dec   count up / count down requests (both or neither = hold)
//   clr       synchronous clear (highest priority)
//   load      synchronous parallel load of load_val (nibbles >9 clamp to 9)
//   load_val  BCD load value, digit i at [4i+3:4i]
//   bcd       current count, digit 0 (LSD) at [3:0]
//   at_max    count is all nines
//   at_min    count is all zeros
//   ovf/unf   one-cycle pulse when an increment at max / decrement at min is attempted
module bcd_counter_ndigit #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned WRAP   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  at_max,
    output logic                  at_min,
    output logic                  ovf,
    output logic                  unf
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] bcd_q, bcd_d;
    logic         at_max_q, at_max_d;
    logic         at_min_q, at_min_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    logic [W-1:0]    inc_val, dec_val, clamp_val;
    logic [DIGITS:0] carry, borrow;
    logic            cur_max, cur_min;

    // True when every nibble of v is 9.
    function automatic logic all_nines(input logic [W-1:0] v);
        logic r;
        r = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) r = 1'b0;
        end
        return r;
    endfunction

    // Ripple incrementer / decrementer and per-digit load clamp.
    always_comb begin
        inc_val   = '0;
        dec_val   = '0;
        clamp_val = '0;
        carry     = '0;
        borrow    = '0;
        carry[0]  = 1'b1;
        borrow[0] = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry[i]) begin
                inc_val[4*i +: 4] = (bcd_q[4*i +: 4] == 4'd9) ? 4'd0 : 4'(bcd_q[4*i +: 4] + 4'd1);
            end else begin
                inc_val[4*i +: 4] = bcd_q[4*i +: 4];
            end
            carry[i+1] = carry[i] & (bcd_q[4*i +: 4] == 4'd9);

            if (borrow[i]) begin
                dec_val[4*i +: 4] = (bcd_q[4*i +: 4] == 4'd0) ? 4'd9 : 4'(bcd_q[4*i +: 4] - 4'd1);
            end else begin
                dec_val[4*i +: 4] = bcd_q[4*i +: 4];
            end
            borrow[i+1] = borrow[i] & (bcd_q[4*i +: 4] == 4'd0);

            clamp_val[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    // Command priority: clr, load, then inc/dec; flags decode the next count.
    always_comb begin
        bcd_d   = bcd_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        cur_max = carry[DIGITS];
        cur_min = borrow[DIGITS];
        if (clr) begin
            bcd_d = '0;
        end else if (load) begin
            bcd_d = clamp_val;
        end else if (inc && !dec) begin
            ovf_d = cur_max;
            // At max the rippled value is already all zeros.
            if (!cur_max || (WRAP != 0)) bcd_d = inc_val;
        end else if (dec && !inc) begin
            unf_d = cur_min;
            // At min the rippled value is already all nines.
            if (!cur_min || (WRAP != 0)) bcd_d = dec_val;
        end
        at_max_d = all_nines(bcd_d);
        at_min_d = (bcd_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_q    <= '0;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            bcd_q    <= bcd_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bcd    = bcd_q;
    assign at_max = at_max_q;
    assign at_min = at_min_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;

endmodule

// File: doc/bcd_counter_ndigit.md
Name: bcd_counter_ndigit

Overview:
Parametrised N-digit BCD up/down counter for the scoreboard and timer datapaths, and the general form of the 2-digit score counter. It adds the following over the 2-digit version:
- configurable digit count
- saturate or wrap mode
- parallel load
- registered limit flags
- overflow/underflow event pulses
Output digits feed the seven-segment encoders directly, one nibble per digit.

Parameters:
DIGITS, 2, number of BCD digits (1..8); count range 0 .. 10^DIGITS-1
WRAP, 0, 0 = hold at max/min; 1 = roll over max->0 and 0->max

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; count=0, flags per reset values
inc  input  1  increment request, sampled on clk
dec  input  1  decrement request, sampled on clk
clr  input  1  synchronous clear to 0
load  input  1  synchronous parallel load
load_val  input  4*DIGITS  BCD value to load; digit i at [4i+3:4i]
bcd  output  4*DIGITS  current count; digit 0 (LSD) at [3:0]
at_max  output  1  count == all nines
at_min  output  1  count == all zeros
ovf  output  1  one-cycle pulse: increment attempted at max
unf  output  1  one-cycle pulse: decrement attempted at min

Behaviour:
- Reset (reset=0, asynchronous):
  - bcd=0, at_min=1, at_max=0, ovf=0, unf=0.
  - Release is synchronised by the parent.
- Command priority per cycle, highest first: clr, load, then inc/dec. Exactly one action per cycle.
- clr=1: bcd<=0; ovf/unf<=0.
- load=1 (clr=0):
  - Each digit <= load_val digit.
  - Any digit >9 (A..F) is clamped to 9 per digit.
  - ovf/unf<=0.
- inc=1 & dec=0:
  - Digit 0 +1. A digit at 9 goes to 0 and carries into the next digit; carry ripples combinationally through all digits within one cycle.
  - At max (all 9s):
    - WRAP=0: hold, ovf<=1.
    - WRAP=1: bcd<=0, ovf<=1.
- dec=1 & inc=0:
  - Digit 0 -1. A digit at 0 goes to 9 and borrows from the next digit.
  - At min (all 0s):
    - WRAP=0: hold, unf<=1.
    - WRAP=1: bcd<=all 9s, unf<=1.
- inc=1 & dec=1, or neither asserted: hold; ovf/unf<=0.
- ovf/unf:
  - Registered, asserted exactly one cycle after the causing edge, i.e. in the same cycle the new bcd is visible.
  - Deasserted every cycle without an event. Never both 1.
- at_max/at_min:
  - Registered flags; must always equal the decode of the current bcd, including after reset, load and clr.
  - DIGITS=1: at_max when bcd==9.
- Latency: every command takes effect on bcd at the first clk edge where it is sampled. There is no pipelining and no internal state beyond the digits and the flags.
- bcd never holds a non-BCD nibble in any cycle.
- Reset asserted mid-count forces the reset values immediately, independent of clk. Commands are ignored while reset=0.

Test Plan:
1. DIGITS=2, WRAP=0: reset, then 100 inc pulses -> bcd counts 00..99 and holds at 99. at_max=1 from count 99; ovf=1 only on the 100th pulse.
2. DIGITS=3, WRAP=1: load 999, then inc -> bcd=000, ovf=1 for one cycle, at_min=1. Then dec -> bcd=999, unf=1, at_max=1.
3. DIGITS=4: load 0x1000, then dec -> bcd=0x0999 (3-digit borrow chain in one cycle). Load 0x09F9 -> bcd=0x0999 (clamp).
4. Simultaneous: at bcd=42, inc=dec=1 -> hold 42. clr+load+inc in the same cycle -> bcd=00. load+inc with load_val=17 -> bcd=17.
5. Async reset: drive reset=0 between clk edges while bcd=57 -> bcd=00, at_min=1, ovf=unf=0 before the next edge. Inputs toggling during reset have no effect.
6. DIGITS=2, WRAP=0: at 00, dec -> hold 00, unf=1. A second dec -> unf=1 again. Then inc -> 01, unf=0.
